// File: rtl/regfile_pkg.sv
// Constants and helpers shared by the register-file write arbiter and the register file.
package regfile_pkg;

    localparam int N_DEFAULT = 16;
    localparam int R_DEFAULT = 4;

    // Requester index width, never narrower than one bit
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Requester-side bus and register-file write port of the write arbiter.
interface regfile_wr_arb_if
    import regfile_pkg::*;
#(
    parameter int n    = N_DEFAULT,
    parameter int r    = R_DEFAULT,
    parameter int NREQ = 3
);

    localparam int IW = idx_width(NREQ);

    logic                     stall;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0][r-1:0]   req_addr;
    logic [NREQ-1:0][n-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     we3;
    logic [r-1:0]             wa3;
    logic [n-1:0]             wd3;
    logic [IW-1:0]            grant_id;
    logic                     collision;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready, we3, wa3, wd3, grant_id, collision
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready, we3, wa3, wd3, grant_id, collision
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant with a rotating priority pointer; grants are
// suppressed while stalled or in reset.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic            accept,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0]   ptr_r;
    logic [NREQ-1:0] pick_s;
    logic [IW-1:0]   cand_s;
    logic            hit_s;
    logic            found_s;

    // First valid requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        pick_s    = {NREQ{1'b0}};
        grant_idx = {IW{1'b0}};
        cand_s    = {IW{1'b0}};
        hit_s     = 1'b0;
        found_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s         = IW'((int'(ptr_r) + i) % NREQ);
            hit_s          = valid[cand_s] & ~found_s;
            pick_s[cand_s] = hit_s;
            grant_idx      = hit_s ? cand_s : grant_idx;
            found_s        = found_s | hit_s;
        end
    end

    assign grant  = (stall | reset) ? {NREQ{1'b0}} : pick_s;
    assign accept = |grant;

    // Pointer moves just past the accepted requester, otherwise holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= {IW{1'b0}};
        end else if (accept) begin
            ptr_r <= (grant_idx == IW'(NREQ - 1)) ? {IW{1'b0}} : grant_idx + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates several register-file write requesters onto the single
// registered write port (we3/wa3/wd3) using round-robin priority.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int n    = N_DEFAULT,
    parameter int r    = R_DEFAULT,
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wr_arb_if.slave    bus
);

    localparam int IW = idx_width(NREQ);

    logic [NREQ-1:0] grant_s;
    logic            accept_s;
    logic [IW-1:0]   idx_s;
    logic [r-1:0]    addr_sel_s;
    logic [n-1:0]    data_sel_s;
    logic            multi_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .stall     (bus.stall),
        .valid     (bus.req_valid),
        .grant     (grant_s),
        .accept    (accept_s),
        .grant_idx (idx_s)
    );

    assign bus.req_ready = grant_s;
    assign addr_sel_s    = bus.req_addr[idx_s];
    assign data_sel_s    = bus.req_data[idx_s];
    // Two or more bits set: clearing the lowest set bit leaves something behind
    assign multi_s       = |(bus.req_valid & (bus.req_valid - NREQ'(1'b1)));

    // Output stage; writes to register 0 are accepted but never enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.we3       <= 1'b0;
            bus.wa3       <= {r{1'b0}};
            bus.wd3       <= {n{1'b0}};
            bus.grant_id  <= {IW{1'b0}};
            bus.collision <= 1'b0;
        end else begin
            bus.collision <= multi_s;
            if (accept_s) begin
                bus.we3      <= |addr_sel_s;
                bus.wa3      <= addr_sel_s;
                bus.wd3      <= data_sel_s;
                bus.grant_id <= idx_s;
            end else begin
                bus.we3      <= 1'b0;
                bus.wa3      <= bus.wa3;
                bus.wd3      <= bus.wd3;
                bus.grant_id <= bus.grant_id;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed, table-driven bench for regfile_wr_arb (3 requesters, 16-bit data, 4-bit address).
module tb_regfile_wr_arb;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic [2:0]  valid;
        logic [11:0] addr;   // {a2,a1,a0}
        logic [47:0] data;   // {d2,d1,d0}
        logic [2:0]  ready;  // expected before the edge
        logic        we;     // expected after the edge
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  gid;
        logic        col;
    } vec_t;

    localparam int NV = 17;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [NV];

    regfile_wr_arb_if #(.n(16), .r(4), .NREQ(3)) bus ();

    regfile_wr_arb #(.n(16), .r(4), .NREQ(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic stall, input logic [2:0] valid,
                                input logic [11:0] addr, input logic [47:0] data,
                                input logic [2:0] ready, input logic we, input logic [3:0] wa,
                                input logic [15:0] wd, input logic [1:0] gid, input logic col);
        vec_t v;
        v.rst = rst; v.stall = stall; v.valid = valid; v.addr = addr; v.data = data;
        v.ready = ready; v.we = we; v.wa = wa; v.wd = wd; v.gid = gid; v.col = col;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic [2:0] valid,
                         input logic [11:0] addr, input logic [47:0] data);
        bus.stall     = stall;
        bus.req_valid = valid;
        bus.req_addr  = addr;
        bus.req_data  = data;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [3:0] wa,
                           input logic [15:0] wd, input logic [1:0] gid, input logic col);
        chk({tag, ".we3"},       48'(bus.we3),       48'(we));
        chk({tag, ".wa3"},       48'(bus.wa3),       48'(wa));
        chk({tag, ".wd3"},       48'(bus.wd3),       48'(wd));
        chk({tag, ".grant_id"},  48'(bus.grant_id),  48'(gid));
        chk({tag, ".collision"}, 48'(bus.collision), 48'(col));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 3'b111, 12'h000, 48'h0);

        // Test 1
        vecs[0]  = mk(1'b0, 1'b0, 3'b001, {4'd0, 4'd0, 4'd5}, {16'h0, 16'h0, 16'hBEEF}, 3'b001, 1'b1, 4'd5, 16'hBEEF, 2'd0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 3'b000, {4'd0, 4'd0, 4'd5}, {16'h0, 16'h0, 16'hBEEF}, 3'b000, 1'b0, 4'd5, 16'hBEEF, 2'd0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b000, 12'h000, 48'h0, 3'b000, 1'b0, 4'd0, 16'h0, 2'd0, 1'b0);
        // Test 2: full contention, pointer starts at 0
        vecs[3]  = mk(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b001, 1'b1, 4'd1, 16'h1111, 2'd0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b010, 1'b1, 4'd2, 16'h2222, 2'd1, 1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b100, 1'b1, 4'd3, 16'h3333, 2'd2, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b001, 1'b1, 4'd1, 16'h1111, 2'd0, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b010, 1'b1, 4'd2, 16'h2222, 2'd1, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 3'b111, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b100, 1'b1, 4'd3, 16'h3333, 2'd2, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 3'b000, {4'd3, 4'd2, 4'd1}, {16'h3333, 16'h2222, 16'h1111}, 3'b000, 1'b0, 4'd3, 16'h3333, 2'd2, 1'b0);
        // Test 3: write to register 0
        vecs[10] = mk(1'b0, 1'b0, 3'b010, {4'd0, 4'd0, 4'd0}, {16'h0, 16'h1234, 16'h0}, 3'b010, 1'b0, 4'd0, 16'h1234, 2'd1, 1'b0);
        // Test 4: accept 2, stall three cycles, then requester 0 wins
        vecs[11] = mk(1'b0, 1'b0, 3'b100, {4'd7, 4'd0, 4'd0}, {16'hABCD, 16'h0, 16'h0}, 3'b100, 1'b1, 4'd7, 16'hABCD, 2'd2, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 3'b011, {4'd0, 4'd10, 4'd9}, {16'h0, 16'h6666, 16'h5555}, 3'b000, 1'b0, 4'd7, 16'hABCD, 2'd2, 1'b1);
        vecs[13] = mk(1'b0, 1'b1, 3'b011, {4'd0, 4'd10, 4'd9}, {16'h0, 16'h6666, 16'h5555}, 3'b000, 1'b0, 4'd7, 16'hABCD, 2'd2, 1'b1);
        vecs[14] = mk(1'b0, 1'b1, 3'b011, {4'd0, 4'd10, 4'd9}, {16'h0, 16'h6666, 16'h5555}, 3'b000, 1'b0, 4'd7, 16'hABCD, 2'd2, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 3'b011, {4'd0, 4'd10, 4'd9}, {16'h0, 16'h6666, 16'h5555}, 3'b001, 1'b1, 4'd9, 16'h5555, 2'd0, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 3'b000, {4'd0, 4'd10, 4'd9}, {16'h0, 16'h6666, 16'h5555}, 3'b000, 1'b0, 4'd9, 16'h5555, 2'd0, 1'b0);

        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst.ready", 48'(bus.req_ready), 48'(3'b000));
        chk_out("rst", 1'b0, 4'd0, 16'h0, 2'd0, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].stall, vecs[i].valid, vecs[i].addr, vecs[i].data);
            #2;
            chk($sformatf("v%0d.ready", i), 48'(bus.req_ready), 48'(vecs[i].ready));
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].gid, vecs[i].col);
        end

        // Test 5: reset right after an acceptance drops that write
        drive(1'b0, 3'b010, {4'd0, 4'd4, 4'd0}, {16'h0, 16'h7777, 16'h0});
        #2;
        chk("t5.ready_pre", 48'(bus.req_ready), 48'(3'b010));
        @(posedge clk);
        #1;
        chk_out("t5.accepted", 1'b1, 4'd4, 16'h7777, 2'd1, 1'b0);
        reset = 1'b1;
        #1;
        chk_out("t5.async", 1'b0, 4'd0, 16'h0, 2'd0, 1'b0);
        drive(1'b0, 3'b110, {4'd8, 4'd6, 4'd0}, {16'h9999, 16'h8888, 16'h0});
        #1;
        chk("t5.ready_in_reset", 48'(bus.req_ready), 48'(3'b000));
        @(posedge clk);
        #1;
        chk_out("t5.held", 1'b0, 4'd0, 16'h0, 2'd0, 1'b0);
        reset = 1'b0;
        #2;
        chk("t5.ready_after", 48'(bus.req_ready), 48'(3'b010));
        @(posedge clk);
        #1;
        chk_out("t5.first", 1'b1, 4'd6, 16'h8888, 2'd1, 1'b1);
        #1;
        chk("t5.ready_next", 48'(bus.req_ready), 48'(3'b100));
        @(posedge clk);
        #1;
        chk_out("t5.second", 1'b1, 4'd8, 16'h9999, 2'd2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
